// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Drives an external 8-function combinational ALU from a valid/ready
//   command stream. An N-bit accumulator always feeds ALU operand a; an
//   operation presents a/b/select for one settle cycle (DRIVE) and then
//   captures the ALU result into the accumulator and the result channel.
//   A load command writes cmd_b straight into the accumulator.
//
//   Optional feature macro: ALU_SEQ_ZFLAG_EN
//     Adds output res_zero, set when the captured value is all zeros.
//
// Ports
//   clk, rst             clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready  command handshake; ready only while IDLE
//   cmd_load             1 = load acc with cmd_b, 0 = ALU op cmd_op
//   cmd_op, cmd_b        ALU select and operand b (or load value)
//   alu_a/alu_b/alu_s    registered ALU operands and select
//   alu_y                ALU result (combinational return)
//   res_valid/res_ready  result handshake
//   res_data             registered result value
//   acc                  current accumulator
//   res_zero             (ALU_SEQ_ZFLAG_EN only) result-is-zero flag
module alu_op_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_load,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_s,
    input  logic [N-1:0] alu_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [N-1:0] acc
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    output logic         res_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t state;

    // Ready is a pure decode of state so a command can be accepted on the
    // very first edge in IDLE.
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
            res_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            acc       <= cmd_b;
                            res_data  <= cmd_b;
                            res_valid <= 1'b1;
`ifdef ALU_SEQ_ZFLAG_EN
                            res_zero  <= (cmd_b == '0);
`endif
                            state     <= RESULT;
                        end else begin
                            // b is registered even for shift ops; the ALU ignores it.
                            alu_a <= acc;
                            alu_b <= cmd_b;
                            alu_s <= cmd_op;
                            state <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    // Operands have been stable for one full cycle; alu_y is settled.
                    acc       <= alu_y;
                    res_data  <= alu_y;
                    res_valid <= 1'b1;
`ifdef ALU_SEQ_ZFLAG_EN
                    res_zero  <= (alu_y == '0);
`endif
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_b = 8'h00;
    logic [7:0] alu_a, alu_b, alu_y, res_data, acc;
    logic [2:0] alu_s;
    logic       res_valid;
    logic       res_ready = 1'b1;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       res_zero;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       z;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .acc(acc)
`ifdef ALU_SEQ_ZFLAG_EN
        , .res_zero(res_zero)
`endif
    );

    // Team 8-function ALU
    always_comb begin
        alu_y = 8'h00;
        case (alu_s)
            3'd0: alu_y = alu_a & alu_b;
            3'd1: alu_y = alu_a | alu_b;
            3'd2: alu_y = ~(alu_a & alu_b);
            3'd3: alu_y = ~(alu_a | alu_b);
            3'd4: alu_y = alu_a ^ alu_b;
            3'd5: alu_y = ~(alu_a ^ alu_b);
            3'd6: alu_y = {alu_a[6:0], 1'b0};
            3'd7: alu_y = {1'b0, alu_a[7:1]};
            default: alu_y = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge with
    // valid & ready both high.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got 0x%0h expected none", res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_res_data", {24'd0, res_data}, {24'd0, e.d});
`ifdef ALU_SEQ_ZFLAG_EN
                chk("sb_res_zero", {31'd0, res_zero}, {31'd0, e.z});
`endif
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Issue one command and check its latency / DRIVE-phase outputs.
    task automatic send(input bit ld, input logic [2:0] op, input logic [7:0] b,
                        input logic [7:0] ea, input logic [7:0] e);
        exp_t x;
        wait_ready();
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_b = b;
        x.d = e; x.z = (e == 8'h00);
        exp_q.push_back(x);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (ld) begin
            chk("load_res_valid_1cyc", {31'd0, res_valid}, 32'd1);
            chk("load_res_data", {24'd0, res_data}, {24'd0, e});
        end else begin
            chk("drive_res_valid_low", {31'd0, res_valid}, 32'd0);
            chk("drive_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("drive_alu_a", {24'd0, alu_a}, {24'd0, ea});
            chk("drive_alu_b", {24'd0, alu_b}, {24'd0, b});
            chk("drive_alu_s", {29'd0, alu_s}, {29'd0, op});
            @(posedge clk); #1;
            chk("op_res_valid_2cyc", {31'd0, res_valid}, 32'd1);
            chk("op_res_data", {24'd0, res_data}, {24'd0, e});
        end
        chk("acc_after_capture", {24'd0, acc}, {24'd0, e});
    endtask

    initial begin
        // Reset asserted at start, then a mid-cycle reassert
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_acc", {24'd0, acc}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_alu_abs", {13'd0, alu_a, alu_b, alu_s}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Load then AND
        send(1'b1, 3'd0, 8'h3C, 8'h00, 8'h3C);
        send(1'b0, 3'd0, 8'h0F, 8'h3C, 8'h0C);
        // Shift overflow / truncation, NAND
        send(1'b1, 3'd5, 8'h81, 8'h00, 8'h81);
        send(1'b0, 3'd6, 8'h33, 8'h81, 8'h02);
        send(1'b0, 3'd7, 8'hAA, 8'h02, 8'h01);
        send(1'b0, 3'd2, 8'hFF, 8'h01, 8'hFE);

        // Backpressure with an ignored command in the window
        send(1'b1, 3'd0, 8'h0F, 8'h00, 8'h0F);
        wait_ready();
        res_ready = 1'b0;
        send(1'b0, 3'd1, 8'hF0, 8'h0F, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 1); cmd_load = 1'b1; cmd_b = 8'h00;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_res_data", {24'd0, res_data}, 32'hFF);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_back_idle", {31'd0, cmd_ready}, 32'd1);
        chk("bp_acc_kept", {24'd0, acc}, 32'hFF);
        chk("bp_res_valid_dropped", {31'd0, res_valid}, 32'd0);

        // Reset during DRIVE: operation lost
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd4; cmd_b = 8'h55;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rd_in_drive_alu_a", {24'd0, alu_a}, 32'hFF);
        rst = 1'b1;
        #1;
        chk("rd_acc", {24'd0, acc}, 32'd0);
        chk("rd_alu_a", {24'd0, alu_a}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rd_no_result", {31'd0, res_valid}, 32'd0);
        end

        // Zero-flag sequence (res_data identical without the macro)
        send(1'b1, 3'd0, 8'hA5, 8'h00, 8'hA5);
        send(1'b0, 3'd4, 8'hA5, 8'hA5, 8'h00);
        send(1'b0, 3'd5, 8'h00, 8'h00, 8'hFF);

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequential initiator that drives the team's 8-function combinational ALU (operands a/b, 3-bit select, result output) from a valid/ready command stream.
- Holds an N-bit accumulator that is always fed to ALU operand a.
- Presents operands and select for one settle cycle, then captures the ALU result into the accumulator.
- Returns the result on a valid/ready result channel.
- Sits between a test/host controller and the ALU datapath.

Parameters:
- N, 8, datapath width of accumulator, operands and result.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_load  input  1  1 = load accumulator with cmd_b; 0 = ALU operation.
- cmd_op  input  3  ALU select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 a×2, 7 a÷2.
- cmd_b  input  N  operand b, or load value.
- alu_a  output  N  to ALU operand a (registered).
- alu_b  output  N  to ALU operand b (registered).
- alu_s  output  3  to ALU select (registered).
- alu_y  input  N  ALU result (combinational return).
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  N  result value (registered).
- acc  output  N  current accumulator value.

Behaviour:
- Reset (async, any state): state=IDLE; acc, alu_a, alu_b, alu_s, res_data = 0; res_valid = 0.
- cmd_ready = 1 only in IDLE; combinational from state.
- Commands are accepted on a rising edge with cmd_valid & cmd_ready.
- IDLE, accept, cmd_load=1:
  - acc <= cmd_b; res_data <= cmd_b; res_valid <= 1; go to RESULT.
  - res_valid rises 1 cycle after the accepting edge.
- IDLE, accept, cmd_load=0:
  - alu_a <= acc; alu_b <= cmd_b; alu_s <= cmd_op; go to DRIVE.
- DRIVE (exactly 1 cycle):
  - At the next edge: acc <= alu_y; res_data <= alu_y; res_valid <= 1; go to RESULT.
  - res_valid is high 2 cycles after the accepting edge.
- RESULT:
  - res_valid and res_data are held stable until res_valid & res_ready at an edge.
  - On that edge: res_valid <= 0; go to IDLE.
  - Minimum command-to-command spacing is 3 cycles for an op and 2 for a load.
- alu_a/alu_b/alu_s hold their last driven values outside DRIVE; they are not cleared.
- Width rules:
  - alu_y is captured exactly; no widening.
  - ×2 overflow and ÷2 truncation are the ALU's (MSB dropped, logical shift).
  - The sequencer adds no carry or sign state.
  - For ops 6/7, cmd_b is still registered onto alu_b; it is don't-care to the ALU.
- cmd_valid while cmd_ready=0: ignored; the command is not latched.
- cmd_op is ignored when cmd_load=1.
- res_ready while res_valid=0: no effect.
- Reset mid-DRIVE or mid-RESULT: the operation is lost; acc = 0; no result is emitted.
- Reset release is asynchronous to this block; the source must deassert rst synchronously to clk.

Optional Feature:
- Macro: ALU_SEQ_ZFLAG_EN.
- Defined:
  - Extra output port res_zero (1 bit), registered alongside res_data.
  - res_zero = 1 iff the captured value (alu_y or load value) is all zeros.
  - Reset value 0; stable while res_valid=1.
- Undefined: port res_zero does not exist; no zero-detect logic is built.

Test Plan (N=8, bench instantiates the team ALU on alu_a/alu_b/alu_s/alu_y):
- Reset asserted mid-cycle, rst=1 → immediately acc=0x00, res_valid=0, alu_a/alu_b/alu_s=0. After release → cmd_ready=1.
- Load 0x3C, then op=0 (AND) with b=0x0F:
  - Load: res_data=0x3C, res_valid 1 cycle after accept.
  - AND: alu_a=0x3C, alu_s=0 during DRIVE; res_data=0x0C and acc=0x0C, res_valid 2 cycles after accept.
- Load 0x81, op=6 → res_data=0x02 (MSB dropped). Then op=7 → res_data=0x01. Then op=2 (NAND) with b=0xFF → res_data=0xFE.
- Backpressure, op=1 (OR) with b=0xF0 on acc=0x0F, res_ready=0 for 5 cycles:
  - res_valid=1, res_data=0xFF stable throughout.
  - cmd_ready=0; a cmd_valid pulse with b=0x00 in that window is not latched.
  - res_ready=1 → back to IDLE, acc still 0xFF.
- Accept op=4 (XOR) b=0x55, assert rst during DRIVE → res_valid never rises; acc=0x00, cmd_ready=1 after release.
- With ALU_SEQ_ZFLAG_EN: load 0xA5, then op=4 with b=0xA5 → res_data=0x00, res_zero=1. Next op=5 (XNOR) with b=0x00 → res_data=0xFF, res_zero=0. Without the macro, the same stimulus gives identical res_data and no res_zero port.
